// File: rtl/dmem_axi_if.sv
// AXI4-Lite bus between the data-memory master and its slave.
// Signal names match the AXI channel names used by the rest of the core.
interface dmem_axi_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] M_AWADDR;
    logic            M_AWVALID;
    logic            M_AWREADY;
    logic [XLEN-1:0] M_WDATA;
    logic [3:0]      M_WSTRB;
    logic            M_WVALID;
    logic            M_WREADY;
    logic [1:0]      M_BRESP;
    logic            M_BVALID;
    logic            M_BREADY;
    logic [XLEN-1:0] M_ARADDR;
    logic            M_ARVALID;
    logic            M_ARREADY;
    logic [XLEN-1:0] M_RDATA;
    logic [1:0]      M_RRESP;
    logic            M_RVALID;
    logic            M_RREADY;

    modport master (
        output M_AWADDR, M_AWVALID, input M_AWREADY,
        output M_WDATA, M_WSTRB, M_WVALID, input M_WREADY,
        input  M_BRESP, M_BVALID, output M_BREADY,
        output M_ARADDR, M_ARVALID, input M_ARREADY,
        input  M_RDATA, M_RRESP, M_RVALID, output M_RREADY
    );

    modport slave (
        input  M_AWADDR, M_AWVALID, output M_AWREADY,
        input  M_WDATA, M_WSTRB, M_WVALID, output M_WREADY,
        output M_BRESP, M_BVALID, input M_BREADY,
        input  M_ARADDR, M_ARVALID, output M_ARREADY,
        output M_RDATA, M_RRESP, M_RVALID, input M_RREADY
    );
endinterface

// File: rtl/dmem_axi_master.sv
// Load/store unit bridging the execute stage to a single-outstanding AXI4-Lite port.
// state   | meaning
// IDLE    | waiting for ld/st request; captures access on request cycle
// RD_ADDR | ARVALID held until AR handshake
// RD_DATA | RREADY high, waiting for read data
// WR_REQ  | AW and W channels each held until their own handshake
// WR_RESP | BREADY high, waiting for write response
// DONE    | one-cycle completion, pipeline released
module dmem_axi_master #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            ld_req_i,
    input  logic            st_req_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            stall_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            err_o,
    dmem_axi_if.master      m_axi
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [1:0]      size_q, size_d;
    logic            unsigned_q, unsigned_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic            err_q, err_d;

    logic            misaligned;
    logic [XLEN-1:0] rshift, ld_data, wdata_lane;
    logic [3:0]      wstrb;
    logic            stall, arvalid, rready, awvalid, wvalid, bready;

    always_comb begin
        case (size_i)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_i[0];
            2'b10:   misaligned = (addr_i[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Half accesses are 2-byte aligned, so a byte-granular shift equals 16*addr[1].
    always_comb begin
        rshift = m_axi.M_RDATA >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00:   ld_data = {{(XLEN-8){~unsigned_q & rshift[7]}}, rshift[7:0]};
            2'b01:   ld_data = {{(XLEN-16){~unsigned_q & rshift[15]}}, rshift[15:0]};
            default: ld_data = m_axi.M_RDATA;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b00: begin
                wstrb      = 4'b0001 << addr_q[1:0];
                wdata_lane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wstrb      = 4'b0011 << {addr_q[1], 1'b0};
                wdata_lane = {2{wdata_q[15:0]}};
            end
            default: begin
                wstrb      = 4'b1111;
                wdata_lane = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        err_d      = 1'b0;
        stall      = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        case (state_q)
            IDLE: begin
                stall = ld_req_i | st_req_i;
                if (ld_req_i | st_req_i) begin
                    addr_d     = addr_i;
                    size_d     = size_i;
                    unsigned_d = unsigned_i;
                    wdata_d    = wdata_i;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    if (misaligned) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (ld_req_i) begin
                        state_d = RD_ADDR;
                    end else begin
                        state_d = WR_REQ;
                    end
                end
            end
            RD_ADDR: begin
                stall   = 1'b1;
                arvalid = 1'b1;
                if (m_axi.M_ARREADY) state_d = RD_DATA;
            end
            RD_DATA: begin
                stall  = 1'b1;
                rready = 1'b1;
                if (m_axi.M_RVALID) begin
                    rdata_d = ld_data;
                    err_d   = |m_axi.M_RRESP;
                    state_d = DONE;
                end
            end
            WR_REQ: begin
                stall     = 1'b1;
                awvalid   = ~aw_done_q;
                wvalid    = ~w_done_q;
                aw_done_d = aw_done_q | (awvalid & m_axi.M_AWREADY);
                w_done_d  = w_done_q | (wvalid & m_axi.M_WREADY);
                if (aw_done_d && w_done_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                stall  = 1'b1;
                bready = 1'b1;
                if (m_axi.M_BVALID) begin
                    err_d   = |m_axi.M_BRESP;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            err_q      <= err_d;
        end
    end

    // IDLE stall follows the request inputs, so it is gated while reset is held.
    assign stall_o         = rstn_i & stall;
    assign rdata_o         = rdata_q;
    assign err_o           = err_q;
    assign m_axi.M_ARADDR  = {addr_q[XLEN-1:2], 2'b00};
    assign m_axi.M_ARVALID = arvalid;
    assign m_axi.M_RREADY  = rready;
    assign m_axi.M_AWADDR  = {addr_q[XLEN-1:2], 2'b00};
    assign m_axi.M_AWVALID = awvalid;
    assign m_axi.M_WDATA   = wdata_lane;
    assign m_axi.M_WSTRB   = wstrb;
    assign m_axi.M_WVALID  = wvalid;
    assign m_axi.M_BREADY  = bready;

endmodule

// File: tb/tb_dmem_axi_master.sv
// Scoreboard bench for dmem_axi_master: directed accesses against a configurable AXI4-Lite slave.
// Drives happen 1 ns after the rising edge; the completion monitor samples on the falling edge.
module tb_dmem_axi_master;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        ld_req_i, st_req_i, unsigned_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, wdata_i, rdata_o;
    logic        stall_o, err_o;

    dmem_axi_if #(.XLEN(32)) bus ();

    dmem_axi_master #(.XLEN(32)) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .ld_req_i   (ld_req_i),
        .st_req_i   (st_req_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .stall_o    (stall_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .m_axi      (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stall;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // slave knobs, set by the stimulus before each access
    int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_rresp = 2'b00, cfg_bresp = 2'b00;
    logic [31:0] exp_addr = '0, exp_wdata = '0;
    logic [3:0]  exp_wstrb = '0;
    logic        rd_expected = 1'b0, wr_expected = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // read slave
    initial begin
        int rph, cnt;
        rph = 0; cnt = 0;
        bus.M_ARREADY = 1'b0; bus.M_RVALID = 1'b0; bus.M_RDATA = '0; bus.M_RRESP = 2'b00;
        forever begin
            @(posedge clk_i); #1;
            if (!rstn_i) begin
                rph = 0; bus.M_ARREADY = 1'b0; bus.M_RVALID = 1'b0;
            end else begin
                case (rph)
                    0: if (bus.M_ARVALID) begin
                        chk("ar_expected", {31'b0, rd_expected}, 32'd1);
                        chk("araddr", bus.M_ARADDR, exp_addr);
                        rd_expected = 1'b0;
                        cnt = 0; rph = 1;
                    end
                    1: if (bus.M_ARREADY) begin
                        bus.M_ARREADY = 1'b0; cnt = 0; rph = 2;
                    end
                    2: if (bus.M_RVALID) begin
                        bus.M_RVALID = 1'b0; rph = 0;
                    end
                    default: rph = 0;
                endcase
                if (rph == 1 && !bus.M_ARREADY) begin
                    if (cnt >= ar_wait) bus.M_ARREADY = 1'b1; else cnt++;
                end
                if (rph == 2 && !bus.M_RVALID) begin
                    if (cnt >= r_wait) begin
                        chk("rready", {31'b0, bus.M_RREADY}, 32'd1);
                        bus.M_RVALID = 1'b1; bus.M_RDATA = cfg_rdata; bus.M_RRESP = cfg_rresp;
                    end else cnt++;
                end
            end
        end
    end

    // write slave
    initial begin
        int  wph, cnt;
        logic awp, wp;
        wph = 0; cnt = 0; awp = 1'b0; wp = 1'b0;
        bus.M_AWREADY = 1'b0; bus.M_WREADY = 1'b0; bus.M_BVALID = 1'b0; bus.M_BRESP = 2'b00;
        forever begin
            @(posedge clk_i); #1;
            if (!rstn_i) begin
                wph = 0; bus.M_AWREADY = 1'b0; bus.M_WREADY = 1'b0; bus.M_BVALID = 1'b0;
            end else begin
                case (wph)
                    0: if (bus.M_AWVALID || bus.M_WVALID) begin
                        chk("aw_expected", {31'b0, wr_expected}, 32'd1);
                        chk("first_awvalid", {31'b0, bus.M_AWVALID}, 32'd1);
                        chk("first_wvalid", {31'b0, bus.M_WVALID}, 32'd1);
                        chk("awaddr", bus.M_AWADDR, exp_addr);
                        chk("wstrb", {28'b0, bus.M_WSTRB}, {28'b0, exp_wstrb});
                        chk("wdata", bus.M_WDATA, exp_wdata);
                        wr_expected = 1'b0;
                        cnt = 0; awp = 1'b1; wp = 1'b1; wph = 1;
                    end
                    1: begin
                        if (bus.M_AWREADY) begin bus.M_AWREADY = 1'b0; awp = 1'b0; end
                        if (bus.M_WREADY)  begin bus.M_WREADY  = 1'b0; wp  = 1'b0; end
                        cnt++;
                        if (!awp && !wp) begin
                            chk("bready", {31'b0, bus.M_BREADY}, 32'd1);
                            bus.M_BVALID = 1'b1; bus.M_BRESP = cfg_bresp; wph = 2;
                        end else if (!awp) begin
                            chk("aw_dropped", {30'b0, bus.M_AWVALID, bus.M_WVALID}, 32'd1);
                        end else if (!wp) begin
                            chk("w_dropped", {30'b0, bus.M_AWVALID, bus.M_WVALID}, 32'd2);
                        end
                    end
                    2: if (bus.M_BVALID) begin
                        bus.M_BVALID = 1'b0; wph = 0;
                    end
                    default: wph = 0;
                endcase
                if (wph == 1) begin
                    bus.M_AWREADY = awp && (cnt >= aw_wait);
                    bus.M_WREADY  = wp && (cnt >= w_wait);
                end
            end
        end
    end

    // completion monitor: a falling stall_o marks DONE
    initial begin
        logic prev;
        int   scnt;
        exp_t e;
        prev = 1'b0; scnt = 0;
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                prev = 1'b0; scnt = 0;
            end else begin
                if (stall_o) scnt++;
                if (prev && !stall_o) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_rdata"}, rdata_o, e.rdata);
                        chk({e.name, "_err"}, {31'b0, err_o}, {31'b0, e.err});
                        if (e.stall > 0) chk({e.name, "_stall_cycles"}, scnt, e.stall);
                    end
                    scnt = 0;
                end else begin
                    chk("err_idle", {31'b0, err_o}, 32'd0);
                end
                prev = stall_o;
            end
        end
    end

    task automatic issue(input string nm, input logic ld, input logic st, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input int es);
        exp_t e;
        int   n;
        e.rdata = er; e.err = ee; e.stall = es; e.name = nm;
        sb.push_back(e);
        ld_req_i = ld; st_req_i = st; size_i = sz; unsigned_i = uns; addr_i = a; wdata_i = wd;
        @(posedge clk_i); #1;
        ld_req_i = 1'b0; st_req_i = 1'b0;
        n = 0;
        while (stall_o === 1'b1 && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk({nm, "_timeout"}, (n < 100) ? 32'd1 : 32'd0, 32'd1);
        chk({nm, "_done_quiet"}, {29'b0, bus.M_ARVALID, bus.M_AWVALID, bus.M_WVALID}, 32'd0);
        @(posedge clk_i); #1;
    endtask

    task automatic rd_cfg(input int aw, input int rw, input logic [31:0] d, input logic [1:0] resp,
                          input logic [31:0] a);
        ar_wait = aw; r_wait = rw; cfg_rdata = d; cfg_rresp = resp; exp_addr = a;
        rd_expected = 1'b1; wr_expected = 1'b0;
    endtask

    task automatic wr_cfg(input int aw, input int ww, input logic [1:0] resp, input logic [31:0] a,
                          input logic [3:0] strb, input logic [31:0] d);
        aw_wait = aw; w_wait = ww; cfg_bresp = resp; exp_addr = a; exp_wstrb = strb; exp_wdata = d;
        wr_expected = 1'b1; rd_expected = 1'b0;
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i = 1'b0; ld_req_i = 1'b1; st_req_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0;
        addr_i = 32'h1000; wdata_i = '0;
        @(negedge clk_i); @(negedge clk_i);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_err", {31'b0, err_o}, 32'd0);
        chk("rst_valids", {29'b0, bus.M_ARVALID, bus.M_AWVALID, bus.M_WVALID}, 32'd0);
        chk("rst_readys", {30'b0, bus.M_RREADY, bus.M_BREADY}, 32'd0);
        ld_req_i = 1'b0;
        @(posedge clk_i); #3 rstn_i = 1'b1;
        @(posedge clk_i); #1;

        rd_cfg(0, 0, 32'hDEADBEEF, 2'b00, 32'h1000);
        issue("lw_zero_wait", 1, 0, 2'b10, 0, 32'h1000, 0, 32'hDEADBEEF, 0, 3);
        rd_cfg(0, 0, 32'h80FF0000, 2'b00, 32'h1000);
        issue("lb_sext", 1, 0, 2'b00, 0, 32'h1003, 0, 32'hFFFFFF80, 0, 3);
        rd_cfg(0, 0, 32'h80FF0000, 2'b00, 32'h1000);
        issue("lbu_zext", 1, 0, 2'b00, 1, 32'h1003, 0, 32'h00000080, 0, 3);
        rd_cfg(0, 0, 32'h80017F00, 2'b00, 32'h1000);
        issue("lh_hi_sext", 1, 0, 2'b01, 0, 32'h1002, 0, 32'hFFFF8001, 0, 3);
        rd_cfg(0, 0, 32'h8001F00D, 2'b00, 32'h1000);
        issue("lhu_lo", 1, 0, 2'b01, 1, 32'h1000, 0, 32'h0000F00D, 0, 3);
        rd_cfg(0, 0, 32'h12347F56, 2'b00, 32'h1000);
        issue("lb_pos", 1, 0, 2'b00, 0, 32'h1001, 0, 32'h0000007F, 0, 3);

        wr_cfg(0, 3, 2'b00, 32'h2000, 4'b1100, 32'hABCDABCD);
        issue("sh_stagger", 0, 1, 2'b01, 0, 32'h2002, 32'h1234ABCD, 32'h0000007F, 0, 6);
        wr_cfg(0, 0, 2'b00, 32'h2000, 4'b0010, 32'h5A5A5A5A);
        issue("sb_lane1", 0, 1, 2'b00, 0, 32'h2001, 32'hCAFE005A, 32'h0000007F, 0, 3);
        wr_cfg(2, 1, 2'b10, 32'h2004, 4'b1111, 32'h11223344);
        issue("sw_slverr", 0, 1, 2'b10, 0, 32'h2004, 32'h11223344, 32'h0000007F, 1, 5);

        rd_cfg(0, 0, 32'h55AA55AA, 2'b10, 32'h1004);
        issue("lw_rresp_err", 1, 0, 2'b10, 0, 32'h1004, 0, 32'h55AA55AA, 1, 3);
        rd_expected = 1'b0;
        issue("lw_misaligned", 1, 0, 2'b10, 0, 32'h1001, 0, 32'h0, 1, 1);
        rd_cfg(0, 0, 32'h0BADF00D, 2'b00, 32'h1008);
        issue("lw_refill", 1, 0, 2'b10, 0, 32'h1008, 0, 32'h0BADF00D, 0, 3);
        rd_expected = 1'b0;
        issue("lh_misaligned", 1, 0, 2'b01, 0, 32'h1003, 0, 32'h0, 1, 1);
        rd_expected = 1'b0;
        issue("size11", 1, 0, 2'b11, 0, 32'h1000, 0, 32'h0, 1, 1);
        rd_cfg(0, 0, 32'hA5A5A5A5, 2'b00, 32'h1000);
        issue("ld_st_both", 1, 1, 2'b10, 0, 32'h1000, 32'hFFFFFFFF, 32'hA5A5A5A5, 0, 3);

        // abort a load while it waits in RD_DATA
        rd_cfg(0, 20, 32'h77777777, 2'b00, 32'h1000);
        ld_req_i = 1'b1; size_i = 2'b10; unsigned_i = 1'b0; addr_i = 32'h1000;
        @(posedge clk_i); #1; ld_req_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("pre_abort_rready", {31'b0, bus.M_RREADY}, 32'd1);
        chk("pre_abort_stall", {31'b0, stall_o}, 32'd1);
        #1 rstn_i = 1'b0;
        #1;
        chk("abort_valids", {30'b0, bus.M_ARVALID, bus.M_RREADY}, 32'd0);
        chk("abort_stall", {31'b0, stall_o}, 32'd0);
        chk("abort_rdata", rdata_o, 32'd0);
        @(posedge clk_i);
        @(posedge clk_i); #3 rstn_i = 1'b1;
        @(posedge clk_i); #1;
        rd_cfg(2, 1, 32'h0F0E0D0C, 2'b00, 32'h3000);
        issue("lw_after_abort", 1, 0, 2'b10, 0, 32'h3000, 0, 32'h0F0E0D0C, 0, 6);

        repeat (3) @(posedge clk_i);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
